// File: rtl/sram_rr_scheduler_pkg.sv
// Shared widths, port indices and write-request packing for the SRAM round-robin scheduler.
package sram_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int WREQ_W = MASK_W + ADDR_W + DATA_W;
  localparam int RET_DEPTH_DEF = 4;
  localparam int MAX_OUTSTANDING_DEF = 8;

  localparam logic [MASK_W-1:0] READ_MASK = 4'h0;

  typedef enum logic [1:0] {
    PORT_W0 = 2'd0,
    PORT_W1 = 2'd1,
    PORT_R0 = 2'd2,
    PORT_R1 = 2'd3
  } port_e;

  function automatic logic [WREQ_W-1:0] pack_wreq(input logic [MASK_W-1:0] mask,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data);
    return {mask, addr, data};
  endfunction

  function automatic logic [MASK_W-1:0] wreq_mask(input logic [WREQ_W-1:0] w);
    return w[WREQ_W-1 -: MASK_W];
  endfunction

  function automatic logic [ADDR_W-1:0] wreq_addr(input logic [WREQ_W-1:0] w);
    return w[DATA_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] wreq_data(input logic [WREQ_W-1:0] w);
    return w[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sram_rr_scheduler_if.sv
// Command/return bus between the scheduler (master) and the ZBT SRAM controller (slave).
interface sram_rr_scheduler_if;
  import sram_arb_pkg::*;

  // Handshake: a command moves when sram_addr_valid & sram_ready at posedge;
  // the master holds valid and payload stable until then. Read data returns
  // in issue order, one word per sram_data_out_valid cycle, with no back-pressure.
  logic              sram_addr_valid;
  logic              sram_ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_in;
  logic [MASK_W-1:0] sram_write_mask;
  logic [DATA_W-1:0] sram_data_out;
  logic              sram_data_out_valid;

  modport master (
    output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  sram_ready, sram_data_out, sram_data_out_valid
  );

  modport slave (
    input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output sram_ready, sram_data_out, sram_data_out_valid
  );

endinterface

// File: rtl/sram_rr_scheduler_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_rr_scheduler.sv
// Four-port round-robin scheduler in front of the SRAM controller, with tag-tracked
// reads steered into per-reader return FIFOs that can never overflow.
module sram_rr_scheduler
  import sram_arb_pkg::*;
#(
  parameter int RET_DEPTH       = RET_DEPTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                w0_din_valid,
  input  logic [WREQ_W-1:0]   w0_din,
  output logic                w0_din_ready,
  input  logic                w1_din_valid,
  input  logic [WREQ_W-1:0]   w1_din,
  output logic                w1_din_ready,
  input  logic                r0_din_valid,
  input  logic [ADDR_W-1:0]   r0_din,
  output logic                r0_din_ready,
  input  logic                r1_din_valid,
  input  logic [ADDR_W-1:0]   r1_din,
  output logic                r1_din_ready,
  output logic [DATA_W-1:0]   r0_dout,
  output logic                r0_dout_valid,
  input  logic                r0_dout_ready,
  output logic [DATA_W-1:0]   r1_dout,
  output logic                r1_dout_valid,
  input  logic                r1_dout_ready,
  sram_rr_scheduler_if.master sram,
  output logic                protocol_err,
  output logic [1:0]          ptr
);

  localparam int RC_W = $clog2(RET_DEPTH + 1);
  localparam int TC_W = $clog2(MAX_OUTSTANDING + 1);

  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [MASK_W-1:0] cmd_mask;
  logic              cmd_rd;
  logic              cmd_rsel;

  logic [RC_W-1:0]   inflight0, inflight1, ret0_count, ret1_count;
  logic [TC_W-1:0]   tag_count;
  logic              tag_empty, tag_head, ret0_empty, ret1_empty;
  logic              rd_xfer, ret_push, pend0, pend1, tag_room;
  logic [3:0]        elig, grant;
  logic              gnt_any;
  logic [1:0]        gnt_idx, scan_idx;
  logic [WREQ_W-1:0] w_sel;

  assign sram.sram_addr_valid = cmd_valid;
  assign sram.sram_addr       = cmd_addr;
  assign sram.sram_data_in    = cmd_data;
  assign sram.sram_write_mask = cmd_mask;

  assign rd_xfer  = cmd_valid & sram.sram_ready & cmd_rd;
  assign ret_push = sram.sram_data_out_valid & ~tag_empty;
  assign pend0    = cmd_valid & cmd_rd & ~cmd_rsel;
  assign pend1    = cmd_valid & cmd_rd & cmd_rsel;

  // A read parked in the command register already owns a tag slot and a return slot.
  assign tag_room = (int'(tag_count) + int'(cmd_valid & cmd_rd)) < MAX_OUTSTANDING;
  assign elig[PORT_W0] = w0_din_valid;
  assign elig[PORT_W1] = w1_din_valid;
  assign elig[PORT_R0] = r0_din_valid & tag_room &
                         ((int'(ret0_count) + int'(inflight0) + int'(pend0)) < RET_DEPTH);
  assign elig[PORT_R1] = r1_din_valid & tag_room &
                         ((int'(ret1_count) + int'(inflight1) + int'(pend1)) < RET_DEPTH);

  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = ptr;
    scan_idx = ptr;
    if (reset && (!cmd_valid || sram.sram_ready)) begin
      for (int i = 0; i < 4; i++) begin
        scan_idx = ptr + 2'(i);
        if (!gnt_any && elig[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign {r1_din_ready, r0_din_ready, w1_din_ready, w0_din_ready} = grant;
  assign w_sel = (gnt_idx == PORT_W1) ? w1_din : w0_din;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cmd_valid    <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      cmd_mask     <= '0;
      cmd_rd       <= 1'b0;
      cmd_rsel     <= 1'b0;
      ptr          <= '0;
      inflight0    <= '0;
      inflight1    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (gnt_any) begin
        cmd_valid <= 1'b1;
        ptr       <= gnt_idx + 2'd1;
        case (gnt_idx)
          PORT_W0, PORT_W1: begin
            cmd_addr <= wreq_addr(w_sel);
            cmd_data <= wreq_data(w_sel);
            cmd_mask <= wreq_mask(w_sel);
            cmd_rd   <= 1'b0;
            cmd_rsel <= 1'b0;
          end
          default: begin
            cmd_addr <= (gnt_idx == PORT_R1) ? r1_din : r0_din;
            cmd_data <= '0;
            cmd_mask <= READ_MASK;
            cmd_rd   <= 1'b1;
            cmd_rsel <= (gnt_idx == PORT_R1);
          end
        endcase
      end else if (cmd_valid && sram.sram_ready) begin
        cmd_valid <= 1'b0;
      end
      case ({rd_xfer & ~cmd_rsel, ret_push & ~tag_head})
        2'b10:   inflight0 <= inflight0 + RC_W'(1);
        2'b01:   inflight0 <= inflight0 - RC_W'(1);
        default: ;
      endcase
      case ({rd_xfer & cmd_rsel, ret_push & tag_head})
        2'b10:   inflight1 <= inflight1 + RC_W'(1);
        2'b01:   inflight1 <= inflight1 - RC_W'(1);
        default: ;
      endcase
      if (sram.sram_data_out_valid && tag_empty) protocol_err <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clock(clock), .reset(reset), .push(rd_xfer), .din(cmd_rsel), .pop(ret_push),
    .dout(tag_head), .count(tag_count), .empty(tag_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RET_DEPTH)) u_ret0_fifo (
    .clock(clock), .reset(reset), .push(ret_push & ~tag_head), .din(sram.sram_data_out),
    .pop(r0_dout_ready), .dout(r0_dout), .count(ret0_count), .empty(ret0_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RET_DEPTH)) u_ret1_fifo (
    .clock(clock), .reset(reset), .push(ret_push & tag_head), .din(sram.sram_data_out),
    .pop(r1_dout_ready), .dout(r1_dout), .count(ret1_count), .empty(ret1_empty)
  );

  assign r0_dout_valid = ~ret0_empty;
  assign r1_dout_valid = ~ret1_empty;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// Directed bench for sram_rr_scheduler: arbitration order, read return path,
// return-FIFO back-pressure, controller stall, protocol error and reset behaviour.
module tb_sram_rr_scheduler;
  import sram_arb_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              w0_din_valid, w1_din_valid, r0_din_valid, r1_din_valid;
  logic [WREQ_W-1:0] w0_din, w1_din;
  logic [ADDR_W-1:0] r0_din, r1_din;
  logic              w0_din_ready, w1_din_ready, r0_din_ready, r1_din_ready;
  logic [DATA_W-1:0] r0_dout, r1_dout;
  logic              r0_dout_valid, r1_dout_valid, r0_dout_ready, r1_dout_ready;
  logic              protocol_err;
  logic [1:0]        ptr;

  int compared   = 0;
  int mismatched = 0;

  logic [ADDR_W-1:0] addr_tab [4];
  logic [MASK_W-1:0] mask_tab [4];
  logic [DATA_W-1:0] data_tab [4];
  int                exp_port [7];
  int                n_r0, n_w0;

  sram_rr_scheduler_if sram();

  sram_rr_scheduler dut (
    .clock(clock), .reset(reset),
    .w0_din_valid(w0_din_valid), .w0_din(w0_din), .w0_din_ready(w0_din_ready),
    .w1_din_valid(w1_din_valid), .w1_din(w1_din), .w1_din_ready(w1_din_ready),
    .r0_din_valid(r0_din_valid), .r0_din(r0_din), .r0_din_ready(r0_din_ready),
    .r1_din_valid(r1_din_valid), .r1_din(r1_din), .r1_din_ready(r1_din_ready),
    .r0_dout(r0_dout), .r0_dout_valid(r0_dout_valid), .r0_dout_ready(r0_dout_ready),
    .r1_dout(r1_dout), .r1_dout_valid(r1_dout_valid), .r1_dout_ready(r1_dout_ready),
    .sram(sram), .protocol_err(protocol_err), .ptr(ptr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    addr_tab = '{18'h00100, 18'h00200, 18'h00300, 18'h00400};
    mask_tab = '{4'hF, 4'h3, 4'h0, 4'h0};
    data_tab = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
    exp_port = '{0, 1, 2, 3, 0, 1, 2};
    w0_din = pack_wreq(4'hF, 18'h00100, 32'h11111111);
    w1_din = pack_wreq(4'h3, 18'h00200, 32'h22222222);
    r0_din = 18'h00300;
    r1_din = 18'h00400;
    {w0_din_valid, w1_din_valid, r0_din_valid, r1_din_valid} = 4'b1111;
    r0_dout_ready = 1'b0;
    r1_dout_ready = 1'b0;
    sram.sram_ready = 1'b1;
    sram.sram_data_out = '0;
    sram.sram_data_out_valid = 1'b0;

    // Reset state, with every requester already asserting valid
    repeat (2) @(posedge clock);
    #1;
    chk("rst_addr_valid", 64'(sram.sram_addr_valid), 64'(0));
    chk("rst_addr", 64'(sram.sram_addr), 64'(0));
    chk("rst_data_in", 64'(sram.sram_data_in), 64'(0));
    chk("rst_mask", 64'(sram.sram_write_mask), 64'(0));
    chk("rst_readys", 64'({r1_din_ready, r0_din_ready, w1_din_ready, w0_din_ready}), 64'(0));
    chk("rst_dout_valid", 64'({r1_dout_valid, r0_dout_valid}), 64'(0));
    chk("rst_perr", 64'(protocol_err), 64'(0));
    chk("rst_ptr", 64'(ptr), 64'(0));

    // All ports valid, controller always ready: w0,w1,r0,r1,w0,w1,r0
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("rr_grant", 64'({r1_din_ready, r0_din_ready, w1_din_ready, w0_din_ready}),
          64'(1) << exp_port[k]);
      if (k > 0) begin
        chk("rr_valid", 64'(sram.sram_addr_valid), 64'(1));
        chk("rr_addr", 64'(sram.sram_addr), 64'(addr_tab[exp_port[k-1]]));
        chk("rr_mask", 64'(sram.sram_write_mask), 64'(mask_tab[exp_port[k-1]]));
        chk("rr_data", 64'(sram.sram_data_in), 64'(data_tab[exp_port[k-1]]));
      end
      step();
    end
    {w0_din_valid, w1_din_valid, r0_din_valid, r1_din_valid} = 4'b0000;
    #1;
    chk("rr_last_addr", 64'(sram.sram_addr), 64'(18'h00300));
    chk("rr_last_mask", 64'(sram.sram_write_mask), 64'(0));
    chk("rr_idle_readys", 64'({r1_din_ready, r0_din_ready, w1_din_ready, w0_din_ready}), 64'(0));
    step();
    chk("rr_drained", 64'(sram.sram_addr_valid), 64'(0));
    chk("rr_ptr", 64'(ptr), 64'(3));

    // Reset with three reads in flight
    reset = 1'b0;
    step();
    chk("mid_rst_valid", 64'(sram.sram_addr_valid), 64'(0));
    chk("mid_rst_addr", 64'(sram.sram_addr), 64'(0));
    chk("mid_rst_mask", 64'(sram.sram_write_mask), 64'(0));
    chk("mid_rst_ptr", 64'(ptr), 64'(0));
    chk("mid_rst_dout_valid", 64'({r1_dout_valid, r0_dout_valid}), 64'(0));
    reset = 1'b1;

    // Late return data with nothing outstanding
    #1;
    chk("perr_before", 64'(protocol_err), 64'(0));
    sram.sram_data_out = 32'h5A5A5A5A;
    sram.sram_data_out_valid = 1'b1;
    step();
    sram.sram_data_out_valid = 1'b0;
    chk("perr_set", 64'(protocol_err), 64'(1));
    chk("perr_dropped", 64'({r1_dout_valid, r0_dout_valid}), 64'(0));
    repeat (3) step();
    chk("perr_sticky", 64'(protocol_err), 64'(1));
    reset = 1'b0;
    step();
    chk("perr_cleared", 64'(protocol_err), 64'(0));
    reset = 1'b1;

    // r0 reads two words, controller returns them three cycles after issue
    r0_din = 18'h00010;
    r0_din_valid = 1'b1;
    #1;
    chk("rd_a_ready", 64'(r0_din_ready), 64'(1));
    step();
    chk("rd_a_valid", 64'(sram.sram_addr_valid), 64'(1));
    chk("rd_a_addr", 64'(sram.sram_addr), 64'(18'h00010));
    chk("rd_a_mask", 64'(sram.sram_write_mask), 64'(0));
    chk("rd_a_data", 64'(sram.sram_data_in), 64'(0));
    r0_din = 18'h00011;
    #1;
    chk("rd_b_ready", 64'(r0_din_ready), 64'(1));
    step();
    r0_din_valid = 1'b0;
    chk("rd_b_addr", 64'(sram.sram_addr), 64'(18'h00011));
    step();
    chk("rd_issued", 64'(sram.sram_addr_valid), 64'(0));
    step();
    sram.sram_data_out = 32'hDEADBEEF;
    sram.sram_data_out_valid = 1'b1;
    step();
    sram.sram_data_out = 32'hCAFEF00D;
    chk("ret_a_valid", 64'(r0_dout_valid), 64'(1));
    chk("ret_a_data", 64'(r0_dout), 64'(32'hDEADBEEF));
    step();
    sram.sram_data_out_valid = 1'b0;
    chk("ret_a_held", 64'(r0_dout), 64'(32'hDEADBEEF));
    chk("ret_r1_idle", 64'(r1_dout_valid), 64'(0));
    r0_dout_ready = 1'b1;
    step();
    chk("ret_b_valid", 64'(r0_dout_valid), 64'(1));
    chk("ret_b_data", 64'(r0_dout), 64'(32'hCAFEF00D));
    step();
    r0_dout_ready = 1'b0;
    chk("ret_empty", 64'(r0_dout_valid), 64'(0));
    chk("ret_r1_still_idle", 64'(r1_dout_valid), 64'(0));
    chk("ret_no_perr", 64'(protocol_err), 64'(0));

    // Controller stall: command held with stable payload, no further accept
    sram.sram_ready = 1'b0;
    w1_din = pack_wreq(4'h5, 18'h2ABCD, 32'h0BADF00D);
    w1_din_valid = 1'b1;
    #1;
    chk("stall_first_ready", 64'(w1_din_ready), 64'(1));
    step();
    w1_din = pack_wreq(4'hA, 18'h01234, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 64'(sram.sram_addr_valid), 64'(1));
      chk("stall_addr", 64'(sram.sram_addr), 64'(18'h2ABCD));
      chk("stall_data", 64'(sram.sram_data_in), 64'(32'h0BADF00D));
      chk("stall_mask", 64'(sram.sram_write_mask), 64'(4'h5));
      chk("stall_no_ready", 64'(w1_din_ready), 64'(0));
      step();
    end
    sram.sram_ready = 1'b1;
    w1_din_valid = 1'b0;
    #1;
    chk("release_addr", 64'(sram.sram_addr), 64'(18'h2ABCD));
    step();
    chk("release_single", 64'(sram.sram_addr_valid), 64'(0));

    // Return FIFO back-pressure: r0 capped at four, w0 keeps being served
    w0_din = pack_wreq(4'hF, 18'h00500, 32'h55555555);
    w0_din_valid = 1'b1;
    r0_din_valid = 1'b1;
    n_r0 = 0;
    n_w0 = 0;
    for (int i = 0; i < 12; i++) begin
      r0_din = 18'h00600 + 18'(n_r0);
      #1;
      if (r0_din_ready) n_r0++;
      if (w0_din_ready) n_w0++;
      step();
    end
    chk("bp_r0_issued", 64'(n_r0), 64'(4));
    chk("bp_w0_served", 64'(n_w0), 64'(8));
    #1;
    chk("bp_r0_blocked", 64'(r0_din_ready), 64'(0));
    chk("bp_w0_ready", 64'(w0_din_ready), 64'(1));
    w0_din_valid = 1'b0;
    sram.sram_data_out = 32'hA5A5A5A5;
    sram.sram_data_out_valid = 1'b1;
    #1;
    chk("bp_ret_blocked", 64'(r0_din_ready), 64'(0));
    step();
    sram.sram_data_out_valid = 1'b0;
    chk("bp_ret_valid", 64'(r0_dout_valid), 64'(1));
    chk("bp_ret_data", 64'(r0_dout), 64'(32'hA5A5A5A5));
    chk("bp_ret_r1_idle", 64'(r1_dout_valid), 64'(0));
    chk("bp_full_blocked", 64'(r0_din_ready), 64'(0));
    r0_dout_ready = 1'b1;
    #1;
    chk("bp_pop_not_credited", 64'(r0_din_ready), 64'(0));
    step();
    r0_dout_ready = 1'b0;
    #1;
    chk("bp_popped", 64'(r0_dout_valid), 64'(0));
    chk("bp_r0_reopened", 64'(r0_din_ready), 64'(1));
    r0_din_valid = 1'b0;
    #1;

    // Final reset with reads still outstanding
    reset = 1'b0;
    step();
    chk("final_ptr", 64'(ptr), 64'(0));
    chk("final_valid", 64'(sram.sram_addr_valid), 64'(0));
    chk("final_dout_valid", 64'({r1_dout_valid, r0_dout_valid}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_rr_scheduler.md
# sram_rr_scheduler

Single-clock, four-port round-robin scheduler sharing the ZBT SRAM controller between two write requesters (image buffer writer, overlay writer) and two read requesters (image buffer reader, an auxiliary reader). It sits between the requesters and the SRAM controller in the 50 MHz SRAM domain, replacing per-port clock crossing for clients already synchronous to it. It tracks in-flight reads with a tag FIFO and steers returned data to per-reader return FIFOs, so reads are issued only when buffer space is guaranteed.

## Interface
- ADDR_W, 18, SRAM word address width
- DATA_W, 32, SRAM data width
- MASK_W, 4, byte write mask width
- RET_DEPTH, 4, entries per reader return FIFO (power of 2)
- MAX_OUTSTANDING, 8, tag FIFO depth, i.e. max reads in flight (power of 2)

- clock  in  1  SRAM-domain clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- w0_din_valid / w1_din_valid  in  1  write request valid
- w0_din / w1_din  in  MASK_W+ADDR_W+DATA_W  {mask, addr, data}; mask must be nonzero
- w0_din_ready / w1_din_ready  out  1  write request accepted this cycle
- r0_din_valid / r1_din_valid  in  1  read request valid
- r0_din / r1_din  in  ADDR_W  read address
- r0_din_ready / r1_din_ready  out  1  read request accepted this cycle
- r0_dout / r1_dout  out  DATA_W  return data (head of return FIFO)
- r0_dout_valid / r1_dout_valid  out  1  return FIFO not empty
- r0_dout_ready / r1_dout_ready  in  1  consumer pops return data
- sram_addr_valid  out  1  command valid to SRAM controller
- sram_ready  in  1  controller accepts command
- sram_addr  out  ADDR_W  command address
- sram_data_in  out  DATA_W  write data (0 for reads)
- sram_write_mask  out  MASK_W  byte enables; 4'h0 = read
- sram_data_out  in  DATA_W  read data
- sram_data_out_valid  in  1  read data valid, in issue order
- protocol_err  out  1  sticky: read data arrived with no outstanding tag

## Operation
- Port order w0=0, w1=1, r0=2, r1=3. Round-robin pointer `ptr` names highest-priority port; grant = first eligible port scanning ptr, ptr+1, ... mod 4.
- Eligible: din_valid high; for reads also (tag FIFO not full) and (return FIFO count + in-flight count for that reader + pending command-register read for that reader) < RET_DEPTH.
- One-entry command register. Grant only when register empty or transferring this cycle (sram_addr_valid & sram_ready). Granted port sees din_ready=1 that cycle; at most one din_ready high per cycle.
- On grant: load register, ptr <= granted+1 mod 4. No grant: ptr unchanged.
- On read transfer to SRAM: push tag (0=r0, 1=r1) to tag FIFO, increment that reader's in-flight count.
- On sram_data_out_valid: pop tag, push sram_data_out to indicated return FIFO, decrement in-flight. If tag FIFO empty: set protocol_err, drop data.
- Return FIFO: show-ahead; pop on dout_valid & dout_ready. Simultaneous push/pop keeps count; eligibility accounting guarantees no overflow.
- Write with mask 0 from a writer is passed as-is (treated as read by controller) — caller error, not checked.

## Timing
- Reset (reset=0 at edge): sram_addr_valid=0, sram_addr=0, sram_data_in=0, sram_write_mask=0, all din_ready=0, all dout_valid=0, protocol_err=0, ptr=0, FIFOs and counts cleared. Reset mid-operation discards in-flight reads; late returned data after reset raises protocol_err.
- din_ready is combinational from valids, counts, sram_ready; no combinational path from din to SRAM outputs.
- Request accepted at edge N -> sram_addr_valid at N+1; back-to-back issue every cycle while sram_ready=1.
- Read data valid at edge M -> dout_valid at M+1.
- sram_addr_valid held with stable payload until sram_ready.

## Structure
- Package sram_arb_pkg: width constants, port index enum, {mask,addr,data} pack/unpack functions, READ_MASK=4'h0.
- Sub-module sync_fifo (parameterised width/depth, show-ahead, count output), instantiated for the tag FIFO (1-bit) and both return FIFOs.

## Test plan
- All four ports valid continuously, sram_ready=1 -> issue order w0,w1,r0,r1,w0,... one per cycle.
- r0 reads A=0x00010, 0x00011 with 3-cycle controller latency returning 0xDEADBEEF, 0xCAFEF00D -> r0_dout yields those in order, r1_dout_valid stays 0.
- r0_dout_ready=0, r0 requests 6 reads, RET_DEPTH=4 -> exactly 4 issued, r0_din_ready=0 thereafter until a pop, w0 still served.
- sram_ready=0 for 5 cycles with w1 valid -> sram_addr_valid=1 payload stable, no further din_ready; released -> single write.
- sram_data_out_valid pulse with nothing outstanding -> protocol_err=1 and stays 1 until reset.
- reset=0 mid-burst with 3 reads in flight -> next cycle all outputs at reset values, ptr=0.
